wb_timer: RTL and testbench

Memory-mapped 64-bit machine timer that sits as a Wishbone B4 pipelined follower on the system bus. It exposes a free-running counter (`mtime`), a compare register (`mtimecmp`) and a control register, and raises a level timer interrupt toward the core when `mtime >= mtimecmp`. It answers every accepted request with exactly one `ack` or `error` and never stalls.

---
 rtl/wb_timer_pkg.sv | 35 +++
 rtl/wb_bus.sv | 27 ++
 rtl/wb_timer_prescaler.sv | 31 +++
 rtl/wb_timer.sv | 182 ++++++++++++++++++
 tb/tb_wb_timer.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_timer_pkg.sv
// Shared definitions for the wb_timer machine timer: register map, CTRL bit
// layout, reset constants and the byte-lane merge helper.
package wb_timer_pkg;

  typedef enum logic [2:0] {
    REG_MTIME_LO    = 3'd0,
    REG_MTIME_HI    = 3'd1,
    REG_MTIMECMP_LO = 3'd2,
    REG_MTIMECMP_HI = 3'd3,
    REG_CTRL        = 3'd4,
    REG_PRESCALE    = 3'd5,
    REG_RESERVED6   = 3'd6,
    REG_RESERVED7   = 3'd7
  } regIndexT;

  localparam int          CTRL_ENABLE_BIT = 0;
  localparam int          PRESCALE_WIDTH  = 16;
  localparam logic [63:0] MTIME_RESET     = 64'd0;
  localparam logic [63:0] MTIMECMP_RESET  = {64{1'b1}};

  // Replace only the byte lanes whose select bit is set.
  function automatic logic [31:0] mergeBytes(input logic [31:0] oldWord,
                                             input logic [31:0] newWord,
                                             input logic [3:0]  sel);
    logic [31:0] result;
    result = oldWord;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) begin
        result[8*i +: 8] = newWord[8*i +: 8];
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/wb_bus.sv
// Wishbone B4 pipelined bus bundle shared by the system bus leader and its
// followers.
interface wb_bus #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 32
);
  logic [DataWidth-1:0]   write_data;
  logic [DataWidth-1:0]   read_data;
  logic [AddrWidth-1:0]   addr;
  logic [DataWidth/8-1:0] select;
  logic                   cycle;
  logic                   strobe;
  logic                   write_enable;
  logic                   ack;
  logic                   stall;
  logic                   error;

  modport follower (
    input  write_data, addr, select, cycle, strobe, write_enable,
    output read_data, ack, stall, error
  );

  modport leader (
    output write_data, addr, select, cycle, strobe, write_enable,
    input  read_data, ack, stall, error
  );
endinterface

// File: rtl/wb_timer_prescaler.sv
// Tick divider for wb_timer: one-cycle tick every prescale+1 enabled cycles.
// Only instantiated when WB_TIMER_PRESCALER_EN is defined.
module wb_timer_prescaler
  import wb_timer_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic                      clear,
  output logic                      tick
);

  logic [PRESCALE_WIDTH-1:0] r_count;
  logic                      w_wrap;

  assign w_wrap = (r_count == prescale);
  assign tick   = enable & ~clear & w_wrap;

  // A clear restarts the period so the first tick after it is a full period away.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= w_wrap ? '0 : r_count + PRESCALE_WIDTH'(1);
    end
  end

endmodule

// File: rtl/wb_timer.sv
// 64-bit machine timer as a never-stalling Wishbone B4 pipelined follower.
// Defining WB_TIMER_PRESCALER_EN adds the PRESCALE register at offset 0x14.
module wb_timer
  import wb_timer_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 32
)
(
  input  logic    clk,
  input  logic    reset,
  wb_bus.follower bus,
  output logic    timer_irq
);

  logic [AddrWidth-1:0] w_addr;
  logic                 w_unusedAddr;
  regIndexT             w_index;
  logic                 w_accept;
  logic                 w_mapped;
  logic                 w_write;
  logic                 w_read;
  logic [DataWidth-1:0] w_readWord;
  logic [63:0]          w_mtimeNext;
  logic [63:0]          w_mtimecmpNext;
  logic                 w_enableNext;
  logic                 w_mtimeWritten;
  logic                 w_tick;

  logic [63:0]          r_mtime;
  logic [63:0]          r_mtimecmp;
  logic                 r_enable;
  logic [31:0]          r_shadow;
  logic                 r_ackPend;
  logic                 r_errPend;
  logic [DataWidth-1:0] r_readData;
  logic                 r_irq;

`ifdef WB_TIMER_PRESCALER_EN
  logic [PRESCALE_WIDTH-1:0] r_prescale;
  logic [PRESCALE_WIDTH-1:0] w_prescaleNext;
  logic                      w_prescaleWrite;
  logic                      w_prescaleClear;
`endif

  assign w_addr       = bus.addr;
  assign w_unusedAddr = ^{w_addr[AddrWidth-1:5], w_addr[1:0]};
  assign w_index      = regIndexT'(w_addr[4:2]);
  assign w_accept     = bus.cycle & bus.strobe;
  assign w_write      = w_accept & bus.write_enable & w_mapped;
  assign w_read       = w_accept & ~bus.write_enable & w_mapped;

  always_comb begin
    w_mapped = 1'b0;
    case (w_index)
      REG_MTIME_LO, REG_MTIME_HI, REG_MTIMECMP_LO, REG_MTIMECMP_HI, REG_CTRL:
        w_mapped = 1'b1;
`ifdef WB_TIMER_PRESCALER_EN
      REG_PRESCALE:
        w_mapped = 1'b1;
`endif
      default:
        w_mapped = 1'b0;
    endcase
  end

  // MTIME_HI returns the shadow so a LO-then-HI read pair is a single snapshot.
  always_comb begin
    w_readWord = '0;
    case (w_index)
      REG_MTIME_LO:    w_readWord = r_mtime[31:0];
      REG_MTIME_HI:    w_readWord = r_shadow;
      REG_MTIMECMP_LO: w_readWord = r_mtimecmp[31:0];
      REG_MTIMECMP_HI: w_readWord = r_mtimecmp[63:32];
      REG_CTRL:        w_readWord[CTRL_ENABLE_BIT] = r_enable;
`ifdef WB_TIMER_PRESCALER_EN
      REG_PRESCALE:    w_readWord = {{(DataWidth-PRESCALE_WIDTH){1'b0}}, r_prescale};
`endif
      default:         w_readWord = '0;
    endcase
  end

  always_comb begin
    w_mtimeNext    = r_mtime;
    w_mtimecmpNext = r_mtimecmp;
    w_enableNext   = r_enable;
    w_mtimeWritten = 1'b0;
`ifdef WB_TIMER_PRESCALER_EN
    w_prescaleNext  = r_prescale;
    w_prescaleWrite = 1'b0;
`endif
    if (w_write) begin
      case (w_index)
        REG_MTIME_LO: begin
          w_mtimeNext[31:0] = mergeBytes(r_mtime[31:0], bus.write_data, bus.select);
          w_mtimeWritten    = 1'b1;
        end
        REG_MTIME_HI: begin
          w_mtimeNext[63:32] = mergeBytes(r_mtime[63:32], bus.write_data, bus.select);
          w_mtimeWritten     = 1'b1;
        end
        REG_MTIMECMP_LO:
          w_mtimecmpNext[31:0] = mergeBytes(r_mtimecmp[31:0], bus.write_data, bus.select);
        REG_MTIMECMP_HI:
          w_mtimecmpNext[63:32] = mergeBytes(r_mtimecmp[63:32], bus.write_data, bus.select);
        REG_CTRL: begin
          if (bus.select[0]) begin
            w_enableNext = bus.write_data[CTRL_ENABLE_BIT];
          end
        end
`ifdef WB_TIMER_PRESCALER_EN
        REG_PRESCALE: begin
          w_prescaleNext  = PRESCALE_WIDTH'(mergeBytes({16'd0, r_prescale},
                                                       bus.write_data, bus.select));
          w_prescaleWrite = 1'b1;
        end
`endif
        default: begin
        end
      endcase
    end
    // A bus write to either half of mtime suppresses this cycle's increment.
    if (!w_mtimeWritten && w_tick) begin
      w_mtimeNext = r_mtime + 64'd1;
    end
  end

`ifdef WB_TIMER_PRESCALER_EN
  assign w_prescaleClear = w_prescaleWrite | (w_enableNext & ~r_enable);

  wb_timer_prescaler u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .enable   (r_enable),
    .prescale (r_prescale),
    .clear    (w_prescaleClear),
    .tick     (w_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prescale <= '0;
    end else begin
      r_prescale <= w_prescaleNext;
    end
  end
`else
  assign w_tick = r_enable;
`endif

  // The interrupt is judged on the values this edge commits, not the old ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mtime    <= MTIME_RESET;
      r_mtimecmp <= MTIMECMP_RESET;
      r_enable   <= 1'b0;
      r_shadow   <= '0;
      r_ackPend  <= 1'b0;
      r_errPend  <= 1'b0;
      r_readData <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_mtime    <= w_mtimeNext;
      r_mtimecmp <= w_mtimecmpNext;
      r_enable   <= w_enableNext;
      if (w_read && (w_index == REG_MTIME_LO)) begin
        r_shadow <= r_mtime[63:32];
      end
      r_ackPend  <= w_accept & w_mapped;
      r_errPend  <= w_accept & ~w_mapped;
      r_readData <= w_read ? w_readWord : '0;
      r_irq      <= w_enableNext & (w_mtimeNext >= w_mtimecmpNext);
    end
  end

  assign bus.ack       = r_ackPend & bus.cycle;
  assign bus.error     = r_errPend & bus.cycle;
  assign bus.read_data = r_readData;
  assign bus.stall     = 1'b0;
  assign timer_irq     = r_irq;

endmodule

// File: tb/tb_wb_timer.sv
// Self-checking bench for wb_timer: register-map vector table plus hand-built
// sequences for the counter, interrupt, snapshot read and reset corner cases.
`timescale 1ns/1ps
module tb_wb_timer;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic        expErr;
    logic [31:0] expData;
    logic        checkData;
  } vectorT;

  typedef struct {
    logic        expErr;
    logic [31:0] expData;
    logic        checkData;
    int          respCycle;
  } expectT;

  logic   clk = 1'b0;
  logic   reset;
  logic   timerIrq;
  int     checks = 0;
  int     errors = 0;
  int     cycleCount = 0;
  expectT scoreQ[$];
  expectT monExp;
  vectorT vecs[$];

  wb_bus #(.DataWidth(32), .AddrWidth(32)) busIf ();

  wb_timer #(.DataWidth(32), .AddrWidth(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (busIf),
    .timer_irq (timerIrq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, required);
    end
  endtask

  // Drive one request just after a clock edge; it is accepted on the next edge.
  task automatic applyStimulus(input logic [31:0] addr, input logic we,
                               input logic [31:0] wdata, input logic [3:0] sel,
                               input logic expErr, input logic [31:0] expData,
                               input logic checkData, input logic expectResp);
    expectT e;
    @(posedge clk);
    #1;
    busIf.cycle        = 1'b1;
    busIf.strobe       = 1'b1;
    busIf.addr         = addr;
    busIf.write_enable = we;
    busIf.write_data   = wdata;
    busIf.select       = sel;
    if (expectResp) begin
      e.expErr    = expErr;
      e.expData   = expData;
      e.checkData = checkData;
      e.respCycle = cycleCount + 1;
      scoreQ.push_back(e);
    end
  endtask

  task automatic writeReg(input logic [31:0] addr, input logic [31:0] data);
    applyStimulus(addr, 1'b1, data, 4'hF, 1'b0, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic readExpect(input logic [31:0] addr, input logic [31:0] data);
    applyStimulus(addr, 1'b0, 32'h0, 4'hF, 1'b0, data, 1'b1, 1'b1);
  endtask

  task automatic idleCycle();
    @(posedge clk);
    #1;
    busIf.cycle        = 1'b1;
    busIf.strobe       = 1'b0;
    busIf.write_enable = 1'b0;
  endtask

  // Response monitor: in-order scoreboard, latency and exclusivity checks.
  always @(negedge clk) begin
    if (!reset) begin
      while (scoreQ.size() > 0 && scoreQ[0].respCycle < cycleCount) begin
        monExp = scoreQ.pop_front();
        checkOutput("missing_response", 32'(cycleCount), 32'(monExp.respCycle));
      end
      if (busIf.ack || busIf.error) begin
        checkOutput("ack_error_exclusive", 32'(busIf.ack & busIf.error), 32'h0);
        checkOutput("stall_low", 32'(busIf.stall), 32'h0);
        if (scoreQ.size() == 0) begin
          checkOutput("unexpected_response", {30'd0, busIf.ack, busIf.error}, 32'h0);
        end else begin
          monExp = scoreQ.pop_front();
          checkOutput("response_cycle", 32'(cycleCount), 32'(monExp.respCycle));
          checkOutput("response_is_error", 32'(busIf.error), 32'(monExp.expErr));
          if (monExp.checkData) begin
            checkOutput("read_data", busIf.read_data, monExp.expData);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs.push_back('{32'h00, 1'b0, 32'h0,        4'hF, 1'b0, 32'h0000_0000, 1'b1});
    vecs.push_back('{32'h04, 1'b0, 32'h0,        4'hF, 1'b0, 32'h0000_0000, 1'b1});
    vecs.push_back('{32'h08, 1'b0, 32'h0,        4'hF, 1'b0, 32'hFFFF_FFFF, 1'b1});
    vecs.push_back('{32'h0C, 1'b0, 32'h0,        4'hF, 1'b0, 32'hFFFF_FFFF, 1'b1});
    vecs.push_back('{32'h10, 1'b0, 32'h0,        4'hF, 1'b0, 32'h0000_0000, 1'b1});
    vecs.push_back('{32'h18, 1'b0, 32'h0,        4'hF, 1'b1, 32'h0000_0000, 1'b1});
    vecs.push_back('{32'h1C, 1'b0, 32'h0,        4'hF, 1'b1, 32'h0000_0000, 1'b1});
`ifdef WB_TIMER_PRESCALER_EN
    vecs.push_back('{32'h14, 1'b0, 32'h0,        4'hF, 1'b0, 32'h0000_0000, 1'b1});
`else
    vecs.push_back('{32'h14, 1'b0, 32'h0,        4'hF, 1'b1, 32'h0000_0000, 1'b1});
`endif
    vecs.push_back('{32'h08, 1'b1, 32'h0000_AB00, 4'h2, 1'b0, 32'h0,        1'b0});
    vecs.push_back('{32'h08, 1'b0, 32'h0,        4'hF, 1'b0, 32'hFFFF_ABFF, 1'b1});
    vecs.push_back('{32'h10, 1'b1, 32'h0000_0001, 4'h0, 1'b0, 32'h0,        1'b0});
    vecs.push_back('{32'h10, 1'b0, 32'h0,        4'hF, 1'b0, 32'h0000_0000, 1'b1});
    vecs.push_back('{32'h1C, 1'b1, 32'h1234_5678, 4'hF, 1'b1, 32'h0,        1'b0});
    vecs.push_back('{32'h0C, 1'b0, 32'h0,        4'hF, 1'b0, 32'hFFFF_FFFF, 1'b1});
    vecs.push_back('{32'h00, 1'b0, 32'h0,        4'hF, 1'b0, 32'h0000_0000, 1'b1});
    vecs.push_back('{32'h1C, 1'b0, 32'h0,        4'hF, 1'b1, 32'h0000_0000, 1'b1});
    vecs.push_back('{32'h08, 1'b0, 32'h0,        4'hF, 1'b0, 32'hFFFF_ABFF, 1'b1});
    vecs.push_back('{32'h10, 1'b0, 32'h0,        4'hF, 1'b0, 32'h0000_0000, 1'b1});

    reset              = 1'b1;
    busIf.cycle        = 1'b0;
    busIf.strobe       = 1'b0;
    busIf.write_enable = 1'b0;
    busIf.addr         = '0;
    busIf.write_data   = '0;
    busIf.select       = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_irq", 32'(timerIrq), 32'h0);
    checkOutput("reset_ack", 32'(busIf.ack), 32'h0);
    checkOutput("reset_error", 32'(busIf.error), 32'h0);
    checkOutput("reset_read_data", busIf.read_data, 32'h0);
    reset       = 1'b0;
    busIf.cycle = 1'b1;

    // Register map table, issued back-to-back one request per cycle.
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].addr, vecs[i].we, vecs[i].wdata, vecs[i].sel,
                    vecs[i].expErr, vecs[i].expData, vecs[i].checkData, 1'b1);
    end
    idleCycle();
    idleCycle();

    // Dropping cycle in the response cycle hides the second response.
    readExpect(32'h00, 32'h0);
    applyStimulus(32'h10, 1'b0, 32'h0, 4'hF, 1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    busIf.cycle  = 1'b0;
    busIf.strobe = 1'b0;
    #1;
    checkOutput("dropped_cycle_ack", 32'(busIf.ack), 32'h0);
    idleCycle();
    idleCycle();

    // Interrupt rises exactly when mtime reaches mtimecmp.
    writeReg(32'h0C, 32'h0);
    writeReg(32'h08, 32'd10);
    writeReg(32'h00, 32'h0);
    writeReg(32'h04, 32'h0);
    writeReg(32'h10, 32'h1);
    idleCycle();
    checkOutput("irq_at_enable", 32'(timerIrq), 32'h0);
    repeat (9) idleCycle();
    checkOutput("irq_mtime_9", 32'(timerIrq), 32'h0);
    idleCycle();
    checkOutput("irq_mtime_10", 32'(timerIrq), 32'h1);
    writeReg(32'h08, 32'd100);
    idleCycle();
    checkOutput("irq_after_cmp_raise", 32'(timerIrq), 32'h0);

    // LO/HI snapshot across the 32-bit carry at several read offsets.
    for (int d = 0; d < 4; d++) begin
      writeReg(32'h10, 32'h0);
      writeReg(32'h00, 32'hFFFF_FFFE);
      writeReg(32'h04, 32'h0);
      writeReg(32'h10, 32'h1);
      for (int j = 0; j < d; j++) idleCycle();
      readExpect(32'h00, 32'(32'hFFFF_FFFE + d));
      readExpect(32'h04, (d >= 2) ? 32'h1 : 32'h0);
      idleCycle();
    end
    writeReg(32'h10, 32'h0);
    idleCycle();
    checkOutput("irq_gated_by_enable", 32'(timerIrq), 32'h0);

`ifdef WB_TIMER_PRESCALER_EN
    writeReg(32'h14, 32'd3);
    writeReg(32'h00, 32'h0);
    writeReg(32'h04, 32'h0);
    writeReg(32'h10, 32'h1);
    for (int k = 1; k <= 12; k++) begin
      readExpect(32'h00, 32'((k - 1) / 4));
    end
    writeReg(32'h10, 32'h0);
    idleCycle();
`endif

    // Reset mid-transaction discards the pending response and clears state.
    writeReg(32'h08, 32'd100);
    writeReg(32'h00, 32'd500);
    writeReg(32'h10, 32'h1);
    idleCycle();
    checkOutput("irq_before_reset", 32'(timerIrq), 32'h1);
    applyStimulus(32'h00, 1'b0, 32'h0, 4'hF, 1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    reset        = 1'b1;
    busIf.strobe = 1'b0;
    #1;
    checkOutput("reset_mid_ack", 32'(busIf.ack), 32'h0);
    checkOutput("reset_mid_irq", 32'(timerIrq), 32'h0);
    checkOutput("reset_mid_read_data", busIf.read_data, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    readExpect(32'h00, 32'h0);
    readExpect(32'h04, 32'h0);
    readExpect(32'h08, 32'hFFFF_FFFF);
    readExpect(32'h10, 32'h0);
    idleCycle();
    idleCycle();
    idleCycle();
    checkOutput("scoreboard_drained", 32'(scoreQ.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
